// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/load controller: host command codes,
// controller state encoding and a small width helper.
package cpu_ctrl_pkg;

    // Host command opcodes carried on cmd_op
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_RUN   = 3'd2,
        OP_STEP  = 3'd3,
        OP_HALT  = 3'd4,
        OP_SETBP = 3'd5,
        OP_CLRBP = 3'd6,
        OP_RSVD  = 3'd7
    } cmd_op_t;

    // Controller states, visible to the host on the state port
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } run_state_t;

    // Number of address bits needed to index a memory of the given depth
    function automatic int addr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

    // States in which setup commands (LOAD, RUN, STEP, breakpoint) are honoured
    function automatic logic accepts_setup(input run_state_t s);
        return (s == ST_IDLE) || (s == ST_HALTED);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over count and
// the value sticks at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count enabled cycles, hold at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/load controller for the single-cycle CPU. Streams a program into
// instruction memory with the CPU held in reset, then runs, single-steps or
// halts the CPU via a per-cycle enable, with one PC breakpoint and a
// saturating executed-cycle counter.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int  INSTR_W    = 32,
    parameter int  PC_W       = 32,
    parameter int  IMEM_DEPTH = 256,
    parameter int  CYC_W      = 32,
    localparam int ADDR_W     = addr_width(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [PC_W-1:0]    cmd_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst_n,
    output logic               cpu_en,
    input  logic [PC_W-1:0]    cpu_pc,
    input  logic               cpu_halt_req,
    output logic [2:0]         state,
    output logic [CYC_W-1:0]   cycle_cnt,
    output logic               bp_hit,
    output logic               done
);

    run_state_t       st;
    cmd_op_t          op;
    logic             cmd_fire;
    logic             ld_fire;
    logic             bpm;
    logic             cnt_clr;
    logic             last_word;
    logic [PC_W-1:0]  ld_num;
    logic [PC_W-1:0]  ld_cnt;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic             skip;

    assign op    = cmd_op_t'(cmd_op);
    assign state = st;

    // Handshake readiness and the per-cycle CPU enable decode from state
    always_comb begin
        cmd_ready = (st == ST_IDLE) || (st == ST_HALTED) || (st == ST_RUN);
        ld_ready  = (st == ST_LOAD);
        cmd_fire  = cmd_valid && cmd_ready;
        ld_fire   = ld_valid && ld_ready;
        // skip lets a RUN resumed from a breakpoint execute the breakpoint PC once
        bpm       = bp_en && (cpu_pc == bp_addr) && !skip;
        cpu_en    = 1'b0;
        if (st == ST_RUN) begin
            cpu_en = !bpm;
        end else if (st == ST_STEP) begin
            cpu_en = 1'b1;
        end
        cnt_clr   = cmd_fire && accepts_setup(st) && (op == OP_LOAD);
        last_word = (ld_cnt == (ld_num - 1'b1));
    end

    sat_counter #(
        .W (CYC_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cpu_en),
        .cnt   (cycle_cnt)
    );

    // Controller FSM with the load path and breakpoint registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            bp_hit     <= 1'b0;
            done       <= 1'b0;
            bp_en      <= 1'b0;
            bp_addr    <= '0;
            skip       <= 1'b0;
            ld_num     <= '0;
            ld_cnt     <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (cpu_en) begin
                skip <= 1'b0;
            end
            case (st)
                ST_IDLE, ST_HALTED: begin
                    if (cmd_fire) begin
                        case (op)
                            OP_LOAD: begin
                                ld_cnt <= '0;
                                ld_num <= cmd_data;
                                bp_hit <= 1'b0;
                                if (cmd_data == '0) begin
                                    st        <= ST_IDLE;
                                    done      <= 1'b1;
                                    cpu_rst_n <= 1'b1;
                                end else begin
                                    st        <= ST_LOAD;
                                    cpu_rst_n <= 1'b0;
                                end
                            end
                            OP_RUN: begin
                                st        <= ST_RUN;
                                cpu_rst_n <= 1'b1;
                                bp_hit    <= 1'b0;
                                skip      <= (st == ST_HALTED);
                            end
                            OP_STEP: begin
                                // a step only makes sense from a halted CPU
                                if (st == ST_HALTED) begin
                                    st     <= ST_STEP;
                                    bp_hit <= 1'b0;
                                end
                            end
                            OP_SETBP: begin
                                bp_addr <= cmd_data;
                                bp_en   <= 1'b1;
                            end
                            OP_CLRBP: begin
                                bp_en <= 1'b0;
                            end
                            OP_NOP, OP_HALT, OP_RSVD: begin
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ld_cnt[ADDR_W-1:0];
                        imem_wdata <= ld_data;
                        ld_cnt     <= ld_cnt + 1'b1;
                        if (last_word) begin
                            st        <= ST_IDLE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // breakpoint beats halt instruction beats host HALT
                    if (bpm) begin
                        st     <= ST_HALTED;
                        bp_hit <= 1'b1;
                        done   <= 1'b1;
                    end else if (cpu_halt_req) begin
                        st   <= ST_HALTED;
                        done <= 1'b1;
                    end else if (cmd_fire && (op == OP_HALT)) begin
                        st   <= ST_HALTED;
                        done <= 1'b1;
                    end
                end
                ST_STEP: begin
                    st   <= ST_HALTED;
                    done <= 1'b1;
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus pushes expected memory writes
// and done events into queues, monitors pop and compare as the DUT emits them.
module tb_cpu_run_ctrl;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 16;
    localparam int CYC_W   = 5;
    localparam int AW      = 4;
    localparam int CMAX    = (1 << CYC_W) - 1;

    localparam logic [2:0] C_NOP = 3'd0, C_LOAD = 3'd1, C_RUN = 3'd2, C_STEP = 3'd3;
    localparam logic [2:0] C_HALT = 3'd4, C_SETBP = 3'd5, C_CLRBP = 3'd6, C_RSVD = 3'd7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [2:0]         cmd_op = 3'd0;
    logic [PC_W-1:0]    cmd_data = '0;
    logic               ld_valid = 1'b0;
    logic               ld_ready;
    logic [INSTR_W-1:0] ld_data = '0;
    logic               imem_we;
    logic [AW-1:0]      imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_rst_n;
    logic               cpu_en;
    logic [PC_W-1:0]    cpu_pc = '0;
    logic               cpu_halt_req;
    logic [2:0]         state;
    logic [CYC_W-1:0]   cycle_cnt;
    logic               bp_hit;
    logic               done;

    logic               halt_en = 1'b0;
    logic [PC_W-1:0]    halt_pc = '0;

    cpu_run_ctrl #(
        .INSTR_W    (INSTR_W),
        .PC_W       (PC_W),
        .IMEM_DEPTH (DEPTH),
        .CYC_W      (CYC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .cpu_en       (cpu_en),
        .cpu_pc       (cpu_pc),
        .cpu_halt_req (cpu_halt_req),
        .state        (state),
        .cycle_cnt    (cycle_cnt),
        .bp_hit       (bp_hit),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Minimal CPU: PC advances one word per enabled cycle, halt at a chosen PC
    always @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) cpu_pc <= '0;
        else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
    end
    assign cpu_halt_req = halt_en && (cpu_pc == halt_pc);

    typedef struct packed { logic [AW-1:0] a; logic [INSTR_W-1:0] d; } wr_t;
    typedef struct packed { logic [2:0] st; logic bp; logic [CYC_W-1:0] cnt; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    wr_t mon_w;
    dn_t mon_d;
    int  total = 0;
    int  bad = 0;

    // reference model state
    int          m_cnt = 0;
    bit          m_bp_en = 0;
    logic [31:0] m_bp = '0;
    logic [31:0] m_pc = '0;
    int          m_state = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitors: compare every memory write and done pulse with the queues
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h required none", imem_addr, imem_wdata);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(mon_w.a));
                chk("wr_data", 64'(imem_wdata), 64'(mon_w.d));
            end
        end
        if (rst_n && done) begin
            if (dq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got state %0d cnt %0d required no pulse", state, cycle_cnt);
            end else begin
                mon_d = dq.pop_front();
                chk("done_state", 64'(state), 64'(mon_d.st));
                chk("done_bp_hit", 64'(bp_hit), 64'(mon_d.bp));
                chk("done_cycle_cnt", 64'(cycle_cnt), 64'(mon_d.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_done(input int st, input bit bp, input int cnt);
        dn_t t;
        t.st = st[2:0];
        t.bp = bp;
        t.cnt = cnt[CYC_W-1:0];
        dq.push_back(t);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] d);
        int b = 0;
        while (!cmd_ready && b < 50) begin
            tick();
            b++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL cmd_ready_timeout: got 0 required 1 (op %0d)", op);
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        tick();
        cmd_valid = 1'b0;
        cmd_op = C_NOP;
        cmd_data = '0;
    endtask

    task automatic wait_done(input int budget);
        int b = 0;
        while ((dq.size() != 0 || wq.size() != 0) && b < budget) begin
            tick();
            b++;
        end
        if (dq.size() != 0 || wq.size() != 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got %0d done %0d writes pending required 0", dq.size(), wq.size());
            dq.delete();
            wq.delete();
        end
    endtask

    // mode 0: one idle cycle between words, data base+i; mode 1: random gaps and data
    task automatic do_load(input int n, input int mode, input logic [31:0] base);
        wr_t w;
        int  g;
        push_done(0, 0, 0);
        send_cmd(C_LOAD, n);
        if (n > 0) begin
            chk("cpu_rst_n_in_load", 64'(cpu_rst_n), 64'd0);
            chk("ld_ready_in_load", 64'(ld_ready), 64'd1);
        end
        for (int i = 0; i < n; i++) begin
            g = (mode == 0) ? ((i > 0) ? 1 : 0) : $urandom_range(0, 2);
            repeat (g) tick();
            w.a = i[AW-1:0];
            w.d = (mode == 0) ? base + i : $urandom();
            wq.push_back(w);
            ld_valid = 1'b1;
            ld_data = w.d;
            tick();
            ld_valid = 1'b0;
        end
        wait_done(50);
        m_cnt = 0;
        m_state = 0;
        if (n > 0) m_pc = '0;
        chk("state_after_load", 64'(state), 64'd0);
        chk("cpu_rst_n_after_load", 64'(cpu_rst_n), 64'd1);
    endtask

    task automatic set_bp(input bit en, input logic [31:0] a);
        if (en) begin
            send_cmd(C_SETBP, a);
            m_bp_en = 1;
            m_bp = a;
        end else begin
            send_cmd(C_CLRBP, '0);
            m_bp_en = 0;
        end
    endtask

    // Walk the program forward until the breakpoint or halt instruction stops it
    task automatic do_run();
        int          ex = -1;
        bit          hitbp = 0;
        bit          sk = (m_state == 4);
        logic [31:0] pc;
        for (int i = 0; i < 64 && ex < 0; i++) begin
            pc = m_pc + 32'(4 * i);
            if (m_bp_en && pc == m_bp && !(i == 0 && sk)) begin
                ex = i;
                hitbp = 1;
            end else if (halt_en && pc == halt_pc) begin
                ex = i + 1;
                hitbp = 0;
            end
        end
        if (ex < 0) ex = 0;
        m_cnt = sat(m_cnt + ex);
        m_pc = m_pc + 32'(4 * ex);
        m_state = 4;
        push_done(4, hitbp, m_cnt);
        send_cmd(C_RUN, '0);
        wait_done(200);
        chk("run_state", 64'(state), 64'd4);
        chk("run_pc", 64'(cpu_pc), 64'(m_pc));
    endtask

    task automatic do_step();
        m_cnt = sat(m_cnt + 1);
        m_pc = m_pc + 32'd4;
        push_done(4, 0, m_cnt);
        send_cmd(C_STEP, '0);
        wait_done(20);
    endtask

    // RUN, a SETBP that RUN must ignore, then a host HALT; k+2 executed cycles
    task automatic do_halt_cmd(input int k);
        logic [31:0] p;
        halt_en = 1'b0;
        set_bp(0, '0);
        p = m_pc;
        m_cnt = sat(m_cnt + k + 2);
        m_pc = m_pc + 32'(4 * (k + 2));
        m_state = 4;
        push_done(4, 0, m_cnt);
        send_cmd(C_RUN, '0);
        repeat (k) tick();
        send_cmd(C_SETBP, p + 32'(4 * (k + 1)));
        send_cmd(C_HALT, '0);
        wait_done(50);
        chk("halt_cmd_pc", 64'(cpu_pc), 64'(m_pc));
    endtask

    initial begin
        // 1: reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("rst_cpu_en", 64'(cpu_en), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("rst_bp_hit", 64'(bp_hit), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_state", 64'(state), 64'd0);
        chk("idle_cpu_en", 64'(cpu_en), 64'd0);

        // 2-3: loads, empty load, wrapping load
        do_load(4, 0, 32'hA0);
        do_load(0, 0, 32'h0);
        do_load(DEPTH + 2, 1, 32'h0);

        // 4: breakpoint at 0x10, then resume past it to a halt at 0x20
        halt_en = 1'b1;
        halt_pc = 32'h20;
        set_bp(1, 32'h10);
        do_run();
        chk("bp_hit_set", 64'(bp_hit), 64'd1);
        chk("bp_cycle_cnt", 64'(cycle_cnt), 64'd4);
        chk("bp_cpu_en_low", 64'(cpu_en), 64'd0);
        do_run();

        // 5: three steps, then halt instruction on the 7th cycle
        repeat (3) do_step();
        halt_pc = m_pc + 32'd24;
        do_run();
        chk("halt_req_bp_hit", 64'(bp_hit), 64'd0);

        // saturation of the cycle counter
        do_halt_cmd(6);
        do_halt_cmd(6);
        chk("cycle_cnt_saturated", 64'(cycle_cnt), 64'(CMAX));

        // STEP and reserved op from IDLE have no effect
        do_load(0, 0, 32'h0);
        send_cmd(C_STEP, '0);
        send_cmd(C_RSVD, 32'h5);
        repeat (3) tick();
        chk("step_idle_state", 64'(state), 64'd0);
        chk("step_idle_cnt", 64'(cycle_cnt), 64'd0);

        // 6: reset during a load after 2 of 5 words
        send_cmd(C_LOAD, 32'd5);
        for (int i = 0; i < 2; i++) begin
            mon_w.a = i[AW-1:0];
            mon_w.d = 32'hC0 + i;
            wq.push_back(mon_w);
            ld_valid = 1'b1;
            ld_data = 32'hC0 + i;
            tick();
            ld_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("midrst_imem_we", 64'(imem_we), 64'd0);
        chk("midrst_ld_ready", 64'(ld_ready), 64'd0);
        chk("midrst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        wq.delete();
        dq.delete();
        m_cnt = 0; m_bp_en = 0; m_bp = '0; m_pc = '0; m_state = 0;
        halt_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_load(1, 0, 32'hD0);

        // randomized mix of loads, runs, steps and host halts
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_load($urandom_range(0, 20), 1, 32'h0);
            end else if (r <= 2 && m_state == 4) begin
                do_step();
            end else if (r <= 4) begin
                do_halt_cmd($urandom_range(0, 5));
            end else begin
                halt_en = 1'b1;
                halt_pc = m_pc + 32'(4 * $urandom_range(0, 10));
                if ($urandom_range(0, 1) == 1) set_bp(1, m_pc + 32'(4 * $urandom_range(0, 10)));
                else set_bp(0, '0);
                do_run();
            end
        end
        repeat (3) tick();
        chk("final_wq_empty", 64'(wq.size()), 64'd0);
        chk("final_dq_empty", 64'(dq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/load controller that sequences the single-cycle CPU.
- Streams a program from a host into instruction memory while holding the CPU in reset.
- Then runs, single-steps or halts the CPU through a per-cycle enable.
- Supports one PC breakpoint and a saturating executed-cycle counter.
- Sits between the host/debug port and the CPU top level.

Parameters:
INSTR_W, 32, instruction/data word width
PC_W, 32, CPU program counter width
IMEM_DEPTH, 256, instruction memory words (power of 2); ADDR_W = log2(IMEM_DEPTH)
CYC_W, 32, cycle counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller accepts command
cmd_op  in  3  0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 HALT, 5 SETBP, 6 CLRBP, 7 reserved
cmd_data  in  PC_W  LOAD: word count N; SETBP: breakpoint PC
ld_valid  in  1  program word valid
ld_ready  out  1  program word accepted
ld_data  in  INSTR_W  program word
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  instruction memory write address
imem_wdata  out  INSTR_W  instruction memory write data
cpu_rst_n  out  1  CPU reset, low while loading
cpu_en  out  1  CPU advances this cycle (combinational from state)
cpu_pc  in  PC_W  current CPU PC
cpu_halt_req  in  1  CPU decoded a halt instruction
state  out  3  0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 HALTED
cycle_cnt  out  CYC_W  enabled cycles since last LOAD, saturating
bp_hit  out  1  sticky, breakpoint caused last halt
done  out  1  one-cycle pulse on LOAD completion or entry to HALTED

Behaviour:
Reset values:
- state IDLE; cmd_ready 1; ld_ready 0; imem_we 0; imem_addr 0; imem_wdata 0.
- cpu_rst_n 0; cpu_en 0; cycle_cnt 0; bp_hit 0; done 0.
- bp_en 0; bp_addr 0; skip 0.
Command handshake:
- A command transfers on cmd_valid & cmd_ready.
- cmd_ready = 1 in IDLE, HALTED and RUN; 0 in LOAD and STEP.
- In RUN only HALT and NOP act; all other ops are accepted and ignored.
- Reserved op: accepted, no effect.
LOAD (from IDLE/HALTED):
- Clears cycle_cnt, bp_hit and write address.
- N = 0: no writes; next state IDLE; done pulses.
- Otherwise ld_ready = 1. Each ld handshake drives registered imem_we=1, imem_addr=cnt, imem_wdata=ld_data one cycle later, then cnt+1.
- Address wraps modulo IMEM_DEPTH; later words overwrite earlier ones.
- After the Nth word: next state IDLE; done pulses with the last write.
- cpu_rst_n = 0 throughout LOAD; 1 in every other state after the first post-reset LOAD or RUN.
RUN (from IDLE/HALTED):
- skip is set on entry from HALTED.
- bpm = bp_en & (cpu_pc == bp_addr) & ~skip.
- cpu_en = ~bpm in RUN; 1 in STEP; 0 otherwise.
- Any cycle with cpu_en = 1: cycle_cnt +1, saturating at all-ones; skip cleared.
- bpm in RUN: cpu_en 0; next state HALTED; bp_hit set; done pulses.
- cpu_halt_req sampled only when cpu_en = 1 (the halt instruction counts as executed); next state HALTED; done pulses.
- HALT command in RUN: the handshake cycle still executes; next state HALTED.
- Priority: breakpoint > halt_req > HALT command. Breakpoint and halt_req cannot both be seen, because bpm gates cpu_en.
STEP (from HALTED only):
- Exactly one cycle with cpu_en = 1, breakpoint ignored; then HALTED and done pulses.
- STEP from IDLE is ignored.
Breakpoint registers:
- SETBP loads bp_addr and sets bp_en; CLRBP clears bp_en.
- Both act in IDLE/HALTED; bp_hit clears on the next RUN/STEP.
Reset mid-operation:
- Asynchronous; all registers return to reset values immediately.
- A partial load is abandoned; imem contents are undefined.

Decomposition:
- Package cpu_ctrl_pkg holds the op code constants, the state encoding, and a width function for ADDR_W.
- One sub-module, sat_counter (parameterised width, enable, sync clear, saturate), implements cycle_cnt.
- The FSM, load path and breakpoint logic stay in cpu_run_ctrl.

Test Plan:
1. Reset with no commands -> state 0, cpu_rst_n 0, cpu_en 0, cmd_ready 1, cycle_cnt 0.
2. LOAD N=4, feed words 0xA0..0xA3 with ld_valid toggling every other cycle -> 4 writes at addr 0..3 with matching data; done pulses with the last write; state returns to IDLE.
3. LOAD N=0 -> no imem_we; done on the next cycle; state IDLE. LOAD N=IMEM_DEPTH+2 -> last two writes land at addr 0 and 1.
4. SETBP 0x10, RUN, cpu_pc counts 0,4,8,0xC,0x10 -> cpu_en 0 when pc=0x10; HALTED; bp_hit 1; cycle_cnt 4. Then RUN -> one enabled cycle at 0x10, execution continues.
5. HALTED, STEP three times -> exactly three single cpu_en pulses, three done pulses, cycle_cnt +3. Then RUN with cpu_halt_req at cycle 7 -> HALTED, bp_hit 0.
6. Assert rst_n low mid-LOAD after 2 of 5 words -> immediate reset values; a new LOAD N=1 starts writing at addr 0.
